// File: rtl/xgmii_encode_64b66b_if.sv
// XGMII 64-bit word bus into the 64b/66b encoder and
// the 66b block stream plus error-block count out of it.
package xgmii_pkg;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic        ena;
    } xgmii64_t;
endpackage

interface xgmii_encode_64b66b_if #(
    parameter int ERR_CNT_W = 16
);
    import xgmii_pkg::*;

    xgmii64_t               xgmii64;
    logic [63:0]            blk_data;
    logic [1:0]             blk_hdr;
    logic                   blk_ena;
    logic [ERR_CNT_W-1:0]   err_cnt;

    modport master (
        output xgmii64,
        input  blk_data,
        input  blk_hdr,
        input  blk_ena,
        input  err_cnt
    );

    modport slave (
        input  xgmii64,
        output blk_data,
        output blk_hdr,
        output blk_ena,
        output err_cnt
    );
endinterface

// File: rtl/xgmii_encode_64b66b.sv
// Clause 49 64b/66b encoder: XGMII word register, classify,
// transmit state machine with E-block substitution.
module xgmii_encode_64b66b #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    xgmii_encode_64b66b_if.slave  bus
);
    localparam logic [7:0] XI = 8'h07;
    localparam logic [7:0] XE = 8'hFE;
    localparam logic [7:0] XS = 8'hFB;
    localparam logic [7:0] XT = 8'hFD;
    localparam logic [7:0] XO = 8'h9C;
    localparam logic [63:0] EBLOCK = {{8{7'h1E}}, 8'h1E};

    typedef enum logic [2:0] {
        TX_INIT, TX_C, TX_D, TX_T, TX_E
    } tx_state_t;

    typedef enum logic [2:0] {
        W_D, W_C, W_O, W_S, W_T, W_E
    } wclass_t;

    logic [63:0]           w_data;
    logic [7:0]            w_ctrl;
    logic                  w_vld;
    tx_state_t             state, state_n, tgt;
    logic [63:0]           data_q, data_n;
    logic [1:0]            hdr_q, hdr_n;
    logic                  ena_q, ena_n;
    logic [ERR_CNT_W-1:0]  err_q, err_n;
    logic [7:0]            lane_code;
    logic [55:0]           c_codes;
    logic [7:0]            t_hit;
    logic [2:0]            t_k;
    wclass_t               wc;
    logic [63:0]           pay;
    logic [1:0]            hdr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_data <= '0;
            w_ctrl <= '0;
            w_vld  <= 1'b0;
        end else begin
            w_vld <= bus.xgmii64.ena;
            if (bus.xgmii64.ena) begin
                w_data <= bus.xgmii64.data;
                w_ctrl <= bus.xgmii64.ctrl;
            end
        end
    end

    always_comb begin
        lane_code = '0;
        c_codes   = '0;
        t_hit     = '0;
        t_k       = '0;
        for (int i = 0; i < 8; i++) begin
            lane_code[i] = w_ctrl[i] &&
                (w_data[8*i +: 8] == XI || w_data[8*i +: 8] == XE);
            c_codes[7*i +: 7] = (w_data[8*i +: 8] == XE) ? 7'h1E : 7'h00;
        end
        // Tk: ctrl set from lane k upward, terminate in k, idle above
        for (int k = 0; k < 8; k++) begin
            t_hit[k] = (w_ctrl == 8'(8'hFF << k)) &&
                       (w_data[8*k +: 8] == XT);
            for (int j = k + 1; j < 8; j++)
                if (w_data[8*j +: 8] != XI) t_hit[k] = 1'b0;
        end
        for (int k = 0; k < 8; k++)
            if (t_hit[k]) t_k = 3'(k);
    end

    always_comb begin
        unique case (1'b1)
            (w_ctrl == 8'h00):
                wc = W_D;
            (&lane_code):
                wc = W_C;
            (w_ctrl == 8'h01 && w_data[7:0] == XS):
                wc = W_S;
            (w_ctrl == 8'hF1 && w_data[7:0] == XO &&
             w_data[63:32] == {4{XI}}):
                wc = W_O;
            (|t_hit):
                wc = W_T;
            default:
                wc = W_E;
        endcase
    end

    always_comb begin
        pay = '0;
        hdr = 2'b01;
        unique case (wc)
            W_D: begin
                hdr = 2'b10;
                pay = w_data;
            end
            W_C: pay = {c_codes, 8'h1E};
            W_S: pay = {w_data[63:8], 8'h78};
            W_O: pay = {28'h0, 4'h0, w_data[31:8], 8'h4B};
            W_T: begin
                unique case (t_k)
                    3'd0: pay[7:0] = 8'h87;
                    3'd1: pay[7:0] = 8'h99;
                    3'd2: pay[7:0] = 8'hAA;
                    3'd3: pay[7:0] = 8'hB4;
                    3'd4: pay[7:0] = 8'hCC;
                    3'd5: pay[7:0] = 8'hD2;
                    3'd6: pay[7:0] = 8'hE1;
                    default: pay[7:0] = 8'hFF;
                endcase
                for (int j = 0; j < 7; j++)
                    if (3'(j) < t_k)
                        pay[8*(j+1) +: 8] = w_data[8*j +: 8];
            end
            default: pay = EBLOCK;
        endcase
    end

    always_comb begin
        state_n = state;
        data_n  = data_q;
        hdr_n   = hdr_q;
        ena_n   = 1'b0;
        err_n   = err_q;
        tgt     = TX_E;
        unique case (state)
            TX_D:
                tgt = (wc == W_D) ? TX_D :
                      (wc == W_T) ? TX_T : TX_E;
            TX_E:
                tgt = (wc == W_D || wc == W_S) ? TX_D :
                      (wc == W_C || wc == W_O) ? TX_C :
                      (wc == W_T) ? TX_T : TX_E;
            default:
                tgt = (wc == W_C || wc == W_O) ? TX_C :
                      (wc == W_S) ? TX_D : TX_E;
        endcase
        if (w_vld) begin
            state_n = tgt;
            ena_n   = 1'b1;
            if (tgt == TX_E) begin
                data_n = EBLOCK;
                hdr_n  = 2'b01;
                err_n  = (&err_q) ? err_q : err_q + 1'b1;
            end else begin
                data_n = pay;
                hdr_n  = hdr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= TX_INIT;
            data_q <= '0;
            hdr_q  <= 2'b00;
            ena_q  <= 1'b0;
            err_q  <= '0;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            hdr_q  <= hdr_n;
            ena_q  <= ena_n;
            err_q  <= err_n;
        end
    end

    assign bus.blk_data = data_q;
    assign bus.blk_hdr  = hdr_q;
    assign bus.blk_ena  = ena_q;
    assign bus.err_cnt  = err_q;
endmodule
